// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg
//   Shared definitions for the program-counter sequencer: default widths,
//   FSM state encoding and the redirect priority order.
//   No ports (package).

package pc_seq_ctrl_pkg;

    localparam int PC_CONTENT_SIZE = 16;
    localparam int PC_IMME_SIZE    = 32;
    localparam int PC_RAS_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Redirect kinds, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_RET  = 3'd1,
        RD_CALL = 3'd2,
        RD_JMP  = 3'd3,
        RD_BR   = 3'd4
    } redir_t;

    function automatic redir_t pick_redirect(input logic ret, input logic call,
                                             input logic jmp, input logic br);
        redir_t r;
        if (ret)       r = RD_RET;
        else if (call) r = RD_CALL;
        else if (jmp)  r = RD_JMP;
        else if (br)   r = RD_BR;
        else           r = RD_NONE;
        return r;
    endfunction

    // True when more than one redirect request is asserted at once.
    function automatic logic multi_redirect(input logic ret, input logic call,
                                            input logic jmp, input logic br);
        logic [3:0] v;
        v = {ret, call, jmp, br};
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack
//   Return-address LIFO. When full, a push overwrites the oldest entry so the
//   most recent DEPTH return addresses are always kept.
//   Ports:
//     clk, rst         clock, async active-high reset (pointer/count only)
//     push, push_data  write push_data on top
//     pop              drop the top entry (ignored when empty; wins over push)
//     top              current top entry (undefined when empty)
//     empty, full      occupancy flags

module pc_ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    // wr_ptr wraps naturally at DEPTH (power of two), which is what makes the
    // overwrite-oldest behaviour fall out for free.
    assign top_ptr = wr_ptr - 1'b1;
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_pop) begin
            wr_ptr <= wr_ptr - 1'b1;
            count  <= count - 1'b1;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full) count <= count + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
//   Next-address sequencer for a reset-less, enable-less program counter.
//   Each cycle it drives sel/imme (sel=1 load imme, sel=0 increment), giving
//   the power-up load to 0, stall-by-reload, halt, and ret/call/jmp/br
//   redirects with a small return-address stack.
//   Ports:
//     clk, rst              clock, async active-high reset
//     cur_addr              counter's current address
//     stall, halt           hold requests (halt is sticky until rst)
//     br_req, br_target     taken branch
//     jmp_req, call_req     jump / call to jmp_target
//     ret_req               return to popped stack address
//     sel, imme             combinational counter controls
//     flush                 registered, high the cycle after a redirect
//     ras_empty, ras_full   stack occupancy
//     halted                FSM in HALT
//     err                   sticky error (empty ret, conflicting requests)
//
//   state | meaning
//   INIT  | force PC=0 on the first edge after reset
//   RUN   | normal sequencing and redirect arbitration
//   HALT  | hold PC until reset

module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int CONTENT_SIZE = PC_CONTENT_SIZE,
    parameter int IMME_SIZE    = PC_IMME_SIZE,
    parameter int RAS_DEPTH    = PC_RAS_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CONTENT_SIZE-1:0] cur_addr,
    input  logic                    stall,
    input  logic                    halt,
    input  logic                    br_req,
    input  logic [CONTENT_SIZE-1:0] br_target,
    input  logic                    jmp_req,
    input  logic                    call_req,
    input  logic [CONTENT_SIZE-1:0] jmp_target,
    input  logic                    ret_req,
    output logic                    sel,
    output logic [IMME_SIZE-1:0]    imme,
    output logic                    flush,
    output logic                    ras_empty,
    output logic                    ras_full,
    output logic                    halted,
    output logic                    err
);

    state_t                  state;
    state_t                  next_state;
    redir_t                  redir;
    logic [CONTENT_SIZE-1:0] load_addr;
    logic [CONTENT_SIZE-1:0] ret_addr;
    logic [CONTENT_SIZE-1:0] ras_top;
    logic                    push;
    logic                    pop;
    logic                    redirect;
    logic                    set_err;

    assign ret_addr = cur_addr + 1'b1;
    assign redir    = pick_redirect(ret_req, call_req, jmp_req, br_req);
    assign imme     = IMME_SIZE'(load_addr);
    assign halted   = (state == ST_HALT);

    pc_ret_stack #(
        .WIDTH (CONTENT_SIZE),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        sel        = 1'b0;
        load_addr  = '0;
        push       = 1'b0;
        pop        = 1'b0;
        redirect   = 1'b0;
        set_err    = 1'b0;
        next_state = state;
        unique case (state)
            ST_INIT: begin
                sel        = 1'b1;
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    sel        = 1'b1;
                    load_addr  = cur_addr;
                    next_state = ST_HALT;
                end else if (stall) begin
                    // Requests are left pending; the requester holds them.
                    sel       = 1'b1;
                    load_addr = cur_addr;
                end else begin
                    set_err = multi_redirect(ret_req, call_req, jmp_req, br_req);
                    unique case (redir)
                        RD_RET: begin
                            if (!ras_empty) begin
                                sel       = 1'b1;
                                load_addr = ras_top;
                                pop       = 1'b1;
                                redirect  = 1'b1;
                            end else begin
                                set_err = 1'b1;
                            end
                        end
                        RD_CALL: begin
                            sel       = 1'b1;
                            load_addr = jmp_target;
                            push      = 1'b1;
                            redirect  = 1'b1;
                        end
                        RD_JMP: begin
                            sel       = 1'b1;
                            load_addr = jmp_target;
                            redirect  = 1'b1;
                        end
                        RD_BR: begin
                            sel       = 1'b1;
                            load_addr = br_target;
                            redirect  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: begin
                sel       = 1'b1;
                load_addr = cur_addr;
            end
            default: begin
                sel        = 1'b1;
                next_state = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            flush <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            flush <= redirect;
            err   <= err | set_err;
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cur_addr;
    logic        stall = 1'b0, halt = 1'b0, br_req = 1'b0, jmp_req = 1'b0;
    logic        call_req = 1'b0, ret_req = 1'b0;
    logic [15:0] br_target = 16'h0, jmp_target = 16'h0;
    logic        sel, flush, ras_empty, ras_full, halted, err;
    logic [31:0] imme;

    logic        preset_en = 1'b0;
    logic [15:0] preset_val = 16'h0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Model of the external program counter: no reset, loads or increments.
    // preset lets the bench place it at an arbitrary address while in reset.
    always @(posedge clk) begin
        if (preset_en)  cur_addr <= preset_val;
        else if (sel)   cur_addr <= imme[15:0];
        else            cur_addr <= cur_addr + 16'd1;
    end

    pc_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cur_addr   (cur_addr),
        .stall      (stall),
        .halt       (halt),
        .br_req     (br_req),
        .br_target  (br_target),
        .jmp_req    (jmp_req),
        .call_req   (call_req),
        .jmp_target (jmp_target),
        .ret_req    (ret_req),
        .sel        (sel),
        .imme       (imme),
        .flush      (flush),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .halted     (halted),
        .err        (err)
    );

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        preset_en = 1'b1; preset_val = 16'h1234;
        #1 rst = 1'b1;
        cyc(); cyc();
        n_checks++; if (cur_addr !== 16'h1234) begin n_fail++; $display("FAIL rst_preset: got %h want %h", cur_addr, 16'h1234); end
        n_checks++; if (sel !== 1'b1) begin n_fail++; $display("FAIL rst_sel: got %b want 1", sel); end
        n_checks++; if (imme !== 32'h0) begin n_fail++; $display("FAIL rst_imme: got %h want 0", imme); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", ras_empty); end
        n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", ras_full); end
        rst = 1'b0; preset_en = 1'b0;
        #1;
        n_checks++; if (sel !== 1'b1 || imme !== 32'h0) begin n_fail++; $display("FAIL init_drive: got sel=%b imme=%h want sel=1 imme=0", sel, imme); end
        cyc();
        n_checks++; if (cur_addr !== 16'h0000) begin n_fail++; $display("FAIL init_pc: got %h want 0000", cur_addr); end
        n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL run_sel: got %b want 0", sel); end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            n_checks++; if (cur_addr !== 16'(i)) begin n_fail++; $display("FAIL incr_%0d: got %h want %h", i, cur_addr, 16'(i)); end
        end
    endtask

    task automatic test_jump();
        cyc(); cyc();
        n_checks++; if (cur_addr !== 16'h0005) begin n_fail++; $display("FAIL jmp_start: got %h want 0005", cur_addr); end
        jmp_req = 1'b1; jmp_target = 16'h0040;
        #1;
        n_checks++; if (sel !== 1'b1 || imme !== 32'h40) begin n_fail++; $display("FAIL jmp_drive: got sel=%b imme=%h want sel=1 imme=40", sel, imme); end
        cyc();
        jmp_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0040) begin n_fail++; $display("FAIL jmp_pc: got %h want 0040", cur_addr); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jmp_flush: got %b want 1", flush); end
        cyc();
        n_checks++; if (cur_addr !== 16'h0041) begin n_fail++; $display("FAIL jmp_next: got %h want 0041", cur_addr); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jmp_flush_clr: got %b want 0", flush); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL jmp_err: got %b want 0", err); end
    endtask

    task automatic test_stall_branch();
        jmp_req = 1'b1; jmp_target = 16'h0007;
        cyc();
        jmp_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0007) begin n_fail++; $display("FAIL stall_start: got %h want 0007", cur_addr); end
        stall = 1'b1; br_req = 1'b1; br_target = 16'h0100;
        #1;
        n_checks++; if (sel !== 1'b1 || imme !== 32'h7) begin n_fail++; $display("FAIL stall_drive: got sel=%b imme=%h want sel=1 imme=7", sel, imme); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (cur_addr !== 16'h0007) begin n_fail++; $display("FAIL stall_hold_%0d: got %h want 0007", i, cur_addr); end
            n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stall_flush_%0d: got %b want 0", i, flush); end
        end
        stall = 1'b0;
        #1;
        n_checks++; if (sel !== 1'b1 || imme !== 32'h100) begin n_fail++; $display("FAIL br_drive: got sel=%b imme=%h want sel=1 imme=100", sel, imme); end
        cyc();
        br_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0100) begin n_fail++; $display("FAIL br_pc: got %h want 0100", cur_addr); end
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", flush); end
        cyc();
        n_checks++; if (cur_addr !== 16'h0101 || flush !== 1'b0) begin n_fail++; $display("FAIL br_next: got pc=%h flush=%b want pc=0101 flush=0", cur_addr, flush); end
    endtask

    task automatic test_call_ret();
        jmp_req = 1'b1; jmp_target = 16'h0010;
        cyc();
        jmp_req = 1'b0;
        call_req = 1'b1; jmp_target = 16'h0080;
        cyc();
        call_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0080 || flush !== 1'b1) begin n_fail++; $display("FAIL call1: got pc=%h flush=%b want pc=0080 flush=1", cur_addr, flush); end
        n_checks++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL call1_empty: got %b want 0", ras_empty); end
        cyc(); cyc();
        n_checks++; if (cur_addr !== 16'h0082) begin n_fail++; $display("FAIL call_seq: got %h want 0082", cur_addr); end
        call_req = 1'b1; jmp_target = 16'h00A0;
        cyc();
        call_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h00A0) begin n_fail++; $display("FAIL call2: got %h want 00a0", cur_addr); end
        ret_req = 1'b1;
        #1;
        n_checks++; if (imme !== 32'h83) begin n_fail++; $display("FAIL ret1_drive: got %h want 83", imme); end
        cyc();
        n_checks++; if (cur_addr !== 16'h0083 || flush !== 1'b1) begin n_fail++; $display("FAIL ret1: got pc=%h flush=%b want pc=0083 flush=1", cur_addr, flush); end
        cyc();
        ret_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0011) begin n_fail++; $display("FAIL ret2: got %h want 0011", cur_addr); end
        n_checks++; if (ras_empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL ret2_flags: got empty=%b err=%b want empty=1 err=0", ras_empty, err); end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] tgt [5];
        logic [15:0] exp_ret [4];
        tgt = '{16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
        exp_ret = '{16'h0501, 16'h0401, 16'h0301, 16'h0201};
        call_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jmp_target = tgt[i];
            cyc();
            n_checks++; if (cur_addr !== tgt[i]) begin n_fail++; $display("FAIL ovf_call_%0d: got %h want %h", i, cur_addr, tgt[i]); end
        end
        call_req = 1'b0;
        n_checks++; if (ras_full !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got full=%b err=%b want full=1 err=0", ras_full, err); end
        ret_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++; if (cur_addr !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret_%0d: got %h want %h", i, cur_addr, exp_ret[i]); end
        end
        n_checks++; if (ras_empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got empty=%b err=%b want empty=1 err=0", ras_empty, err); end
        #1;
        n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL ret_empty_sel: got %b want 0", sel); end
        cyc();
        ret_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0202) begin n_fail++; $display("FAIL ret_empty_pc: got %h want 0202", cur_addr); end
        n_checks++; if (err !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL ret_empty_flags: got err=%b flush=%b want err=1 flush=0", err, flush); end
    endtask

    task automatic test_halt();
        jmp_req = 1'b1; jmp_target = 16'h0020;
        cyc();
        n_checks++; if (cur_addr !== 16'h0020) begin n_fail++; $display("FAIL halt_start: got %h want 0020", cur_addr); end
        halt = 1'b1; jmp_target = 16'h0300;
        #1;
        n_checks++; if (sel !== 1'b1 || imme !== 32'h20) begin n_fail++; $display("FAIL halt_drive: got sel=%b imme=%h want sel=1 imme=20", sel, imme); end
        cyc();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (cur_addr !== 16'h0020 || halted !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_hold_%0d: got pc=%h halted=%b flush=%b want pc=0020 halted=1 flush=0", i, cur_addr, halted, flush); end
            cyc();
        end
        rst = 1'b1;
        #1;
        n_checks++; if (sel !== 1'b1 || imme !== 32'h0) begin n_fail++; $display("FAIL halt_rst_drive: got sel=%b imme=%h want sel=1 imme=0", sel, imme); end
        n_checks++; if (err !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_rst_flags: got err=%b halted=%b want err=0 halted=0", err, halted); end
        jmp_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++; if (cur_addr !== 16'h0000) begin n_fail++; $display("FAIL rerun_pc0: got %h want 0000", cur_addr); end
        cyc();
        n_checks++; if (cur_addr !== 16'h0001) begin n_fail++; $display("FAIL rerun_pc1: got %h want 0001", cur_addr); end
    endtask

    task automatic test_wrap();
        jmp_req = 1'b1; jmp_target = 16'hFFFF;
        cyc();
        jmp_req = 1'b0;
        n_checks++; if (cur_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_start: got %h want ffff", cur_addr); end
        call_req = 1'b1; jmp_target = 16'h0050;
        cyc();
        call_req = 1'b0;
        ret_req = 1'b1;
        #1;
        n_checks++; if (imme !== 32'h0) begin n_fail++; $display("FAIL wrap_push: got %h want 0", imme); end
        cyc();
        ret_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0000 || flush !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL wrap_ret: got pc=%h flush=%b err=%b want pc=0000 flush=1 err=0", cur_addr, flush, err); end
    endtask

    task automatic test_conflict();
        jmp_req = 1'b1; br_req = 1'b1; jmp_target = 16'h0070; br_target = 16'h0090;
        cyc();
        jmp_req = 1'b0; br_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0070 || err !== 1'b1) begin n_fail++; $display("FAIL jmp_br: got pc=%h err=%b want pc=0070 err=1", cur_addr, err); end
        call_req = 1'b1; jmp_target = 16'h0120;
        cyc();
        ret_req = 1'b1; jmp_target = 16'h0400;
        cyc();
        ret_req = 1'b0; call_req = 1'b0;
        n_checks++; if (cur_addr !== 16'h0071) begin n_fail++; $display("FAIL ret_call: got %h want 0071", cur_addr); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_call_empty: got %b want 1", ras_empty); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_stall_branch();
        test_call_ret();
        test_ras_overflow();
        test_halt();
        test_wrap();
        test_conflict();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
